hazard_unit: RTL

Scoreboard-based hazard and forwarding unit for the pipelined Thumb core. It sits directly downstream of the decode-stage register-address decoder and consumes its source and destination register addresses. It tracks the destinations of instructions in flight in EX and MEM, stalls decode on load-use hazards by injecting a bubble into EX, and issues registered forwarding selects that the EX operand muxes use.

---
 rtl/hazard_unit_pkg.sv | 28 ++
 rtl/hazard_unit_fwd_match.sv | 34 +++
 rtl/hazard_unit.sv | 87 ++++++++
 3 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the decode-stage hazard/forwarding unit.
package hazard_unit_pkg;

    localparam int ADDR_WIDTH = 4;

    // r15 is the PC; it is never tracked in the scoreboard and never forwarded.
    localparam logic [ADDR_WIDTH-1:0] PC_ADDR = 4'd15;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] dest;
        logic                  is_load;
    } tracker_entry_t;

    // True when a used, non-PC source reads the destination held by a live entry.
    function automatic logic entry_hit(input tracker_entry_t entry,
                                       input logic [ADDR_WIDTH-1:0] src,
                                       input logic use_src);
        return use_src && entry.valid && (entry.dest == src) && (src != PC_ADDR);
    endfunction

endpackage

// File: rtl/hazard_unit_fwd_match.sv
// Per-source comparison of one decode source against the EX and MEM entries.
module fwd_match
    import hazard_unit_pkg::*;
(
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic                  use_src,
    input  tracker_entry_t        ex_entry,
    input  tracker_entry_t        mem_entry,
    output fwd_sel_t              fwd_sel,
    output logic                  ex_load_hit
);

    logic ex_hit;
    logic mem_hit;

    // A load in MEM is already forwardable from WB next cycle, so its load flag
    // plays no part in the match.
    logic mem_is_load_unused;
    assign mem_is_load_unused = mem_entry.is_load;

    // EX entry is the younger producer, so it wins over MEM.
    always_comb begin
        ex_hit      = entry_hit(ex_entry, src_addr, use_src);
        mem_hit     = entry_hit(mem_entry, src_addr, use_src);
        fwd_sel     = FWD_NONE;
        ex_load_hit = ex_hit && ex_entry.is_load;
        if (ex_hit) begin
            fwd_sel = FWD_MEM;
        end else if (mem_hit) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Scoreboard hazard unit: load-use stall/bubble and registered EX forwarding selects.
module hazard_unit
    import hazard_unit_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  id_valid_i,
    input  logic [ADDR_WIDTH-1:0] id_reg_addr_1_i,
    input  logic [ADDR_WIDTH-1:0] id_reg_addr_2_i,
    input  logic [ADDR_WIDTH-1:0] id_reg_dest_addr_i,
    input  logic                  id_uses_src1_i,
    input  logic                  id_uses_src2_i,
    input  logic                  id_writes_dest_i,
    input  logic                  id_is_load_i,
    input  logic                  flush_i,
    input  logic                  mem_stall_i,
    output logic                  stall_o,
    output logic                  bubble_o,
    output fwd_sel_t              fwd_sel_1_o,
    output fwd_sel_t              fwd_sel_2_o
);

    tracker_entry_t ex_q;
    tracker_entry_t mem_q;
    tracker_entry_t push;
    fwd_sel_t       sel_1;
    fwd_sel_t       sel_2;
    fwd_sel_t       fwd_sel_1_q;
    fwd_sel_t       fwd_sel_2_q;
    logic           ex_load_hit_1;
    logic           ex_load_hit_2;
    logic           load_use;

    fwd_match u_match_1 (
        .src_addr    (id_reg_addr_1_i),
        .use_src     (id_uses_src1_i),
        .ex_entry    (ex_q),
        .mem_entry   (mem_q),
        .fwd_sel     (sel_1),
        .ex_load_hit (ex_load_hit_1)
    );

    fwd_match u_match_2 (
        .src_addr    (id_reg_addr_2_i),
        .use_src     (id_uses_src2_i),
        .ex_entry    (ex_q),
        .mem_entry   (mem_q),
        .fwd_sel     (sel_2),
        .ex_load_hit (ex_load_hit_2)
    );

    assign load_use = id_valid_i && !flush_i && (ex_load_hit_1 || ex_load_hit_2);
    assign stall_o  = load_use || mem_stall_i;
    assign bubble_o = load_use && !mem_stall_i;

    // Entry entering EX; a stalled or flushed decode instruction leaves a hole.
    always_comb begin
        push.valid   = id_valid_i && id_writes_dest_i && (id_reg_dest_addr_i != PC_ADDR)
                       && !flush_i && !load_use;
        push.dest    = id_reg_dest_addr_i;
        push.is_load = id_is_load_i;
    end

    // Advance the tracker and register the selects unless memory freezes the pipe.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            ex_q        <= '0;
            mem_q       <= '0;
            fwd_sel_1_q <= FWD_NONE;
            fwd_sel_2_q <= FWD_NONE;
        end else if (!mem_stall_i) begin
            ex_q  <= push;
            mem_q <= ex_q;
            if (id_valid_i && !flush_i && !load_use) begin
                fwd_sel_1_q <= sel_1;
                fwd_sel_2_q <= sel_2;
            end else begin
                fwd_sel_1_q <= FWD_NONE;
                fwd_sel_2_q <= FWD_NONE;
            end
        end
    end

    assign fwd_sel_1_o = fwd_sel_1_q;
    assign fwd_sel_2_o = fwd_sel_2_q;

endmodule
